ram_bus_master: RTL and testbench

RAM_BUS_MASTER -- requirements
Module: ram_bus_master

---
 rtl/hc4_mem_pkg.sv | 26 ++
 rtl/ram_bus_master.sv | 139 +++++++++++++
 tb/tb_ram_bus_master.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hc4_mem_pkg.sv
// hc4_mem_pkg -- shared definitions for the hc4 nibble-RAM bus master.
//   mem_state_t        : bus-cycle phase encoding
//   DEF_*_CYCLES       : default phase lengths (setup / strobe / hold)
//   phase_len_ok()     : legal range check for a phase-length parameter
package hc4_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } mem_state_t;

   localparam int DEF_SETUP_CYCLES  = 1;
   localparam int DEF_STROBE_CYCLES = 2;
   localparam int DEF_HOLD_CYCLES   = 1;

   // Phase lengths must fit the shared 4-bit down-counter and be non-zero.
   localparam int PHASE_LEN_MIN = 1;
   localparam int PHASE_LEN_MAX = 15;

   function automatic logic phase_len_ok(input int n);
      return (n >= PHASE_LEN_MIN) && (n <= PHASE_LEN_MAX);
   endfunction

endpackage

// File: rtl/ram_bus_master.sv
// ram_bus_master -- sequences single read/write cycles to an asynchronous
// 256 x 4 RAM with programmable setup / strobe / hold phase lengths.
//
// Ports
//   clk                 : single clock, rising edge
//   nrst                : asynchronous active-low reset
//   req_valid/req_ready : core request handshake (ready only when idle)
//   req_write           : 1 = write, 0 = read
//   req_addr, req_wdata : nibble address, write data
//   rsp_valid           : one-cycle pulse after a read completes
//   rsp_rdata           : last read data, held until the next read capture
//   mem_address         : RAM address
//   mem_data_out/_oe    : write data and its output enable (tri-state built above)
//   mem_data_in         : RAM read data
//   mem_nwrite_enable   : active-low write strobe
//   mem_nread_enable    : active-low read strobe
//
// State table
//   state     | meaning
//   ST_IDLE   | waiting for a request, req_ready = 1
//   ST_SETUP  | address (and write data) stable, strobes high
//   ST_STROBE | one strobe low for STROBE_CYCLES
//   ST_HOLD   | strobes high again, address/data still held
//
// All mem_* outputs are registered and updated as a function of the next
// state, so each one switches cleanly on the edge that enters a phase.
module ram_bus_master
   import hc4_mem_pkg::*;
#(
   parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
   parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [7:0] req_addr,
   input  logic [3:0] req_wdata,
   output logic       rsp_valid,
   output logic [3:0] rsp_rdata,
   output logic [7:0] mem_address,
   output logic [3:0] mem_data_out,
   output logic       mem_data_oe,
   input  logic [3:0] mem_data_in,
   output logic       mem_nwrite_enable,
   output logic       mem_nread_enable
);

   if (!phase_len_ok(SETUP_CYCLES) || !phase_len_ok(STROBE_CYCLES) ||
       !phase_len_ok(HOLD_CYCLES)) begin : g_bad_phase_len
      $error("ram_bus_master: phase lengths must be within 1..15");
   end

   // Counter reload values: a phase lasts N cycles when loaded with N-1.
   localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
   localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
   localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);

   mem_state_t state;
   logic [3:0] phase_cnt;
   logic       cur_write;
   logic       phase_done;

   assign req_ready  = (state == ST_IDLE);
   assign phase_done = (phase_cnt == 4'd0);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state             <= ST_IDLE;
         phase_cnt         <= 4'd0;
         cur_write         <= 1'b0;
         mem_address       <= 8'h00;
         mem_data_out      <= 4'h0;
         mem_data_oe       <= 1'b0;
         mem_nwrite_enable <= 1'b1;
         mem_nread_enable  <= 1'b1;
         rsp_valid         <= 1'b0;
         rsp_rdata         <= 4'h0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  state       <= ST_SETUP;
                  phase_cnt   <= SETUP_LD;
                  cur_write   <= req_write;
                  mem_address <= req_addr;
                  // Leave the data bus untouched on reads to avoid needless toggling.
                  if (req_write) begin
                     mem_data_out <= req_wdata;
                  end
                  mem_data_oe <= req_write;
               end
            end
            ST_SETUP: begin
               if (phase_done) begin
                  state     <= ST_STROBE;
                  phase_cnt <= STROBE_LD;
                  if (cur_write) begin
                     mem_nwrite_enable <= 1'b0;
                  end else begin
                     mem_nread_enable <= 1'b0;
                  end
               end else begin
                  phase_cnt <= phase_cnt - 4'd1;
               end
            end
            ST_STROBE: begin
               if (phase_done) begin
                  state             <= ST_HOLD;
                  phase_cnt         <= HOLD_LD;
                  mem_nwrite_enable <= 1'b1;
                  mem_nread_enable  <= 1'b1;
                  if (!cur_write) begin
                     rsp_rdata <= mem_data_in;
                  end
               end else begin
                  phase_cnt <= phase_cnt - 4'd1;
               end
            end
            ST_HOLD: begin
               if (phase_done) begin
                  state       <= ST_IDLE;
                  mem_data_oe <= 1'b0;
                  rsp_valid   <= !cur_write;
               end else begin
                  phase_cnt <= phase_cnt - 4'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_bus_master.sv
// tb_ram_bus_master -- directed bench for ram_bus_master with a 256 x 4
// RAM model (async read, write sampled while the write strobe is low) and a
// second instance using non-default phase lengths.
module tb_ram_bus_master;

   logic       clk = 1'b0;
   logic       nrst;
   logic       req_valid, req_write, req_ready;
   logic [7:0] req_addr;
   logic [3:0] req_wdata;
   logic       rsp_valid;
   logic [3:0] rsp_rdata;
   logic [7:0] mem_address;
   logic [3:0] mem_data_out, mem_data_in;
   logic       mem_data_oe, mem_nwrite_enable, mem_nread_enable;

   logic       d2_req_valid, d2_req_write, d2_req_ready;
   logic [7:0] d2_req_addr;
   logic [3:0] d2_req_wdata;
   logic       d2_rsp_valid;
   logic [3:0] d2_rsp_rdata;
   logic [7:0] d2_mem_address;
   logic [3:0] d2_mem_data_out, d2_mem_data_in;
   logic       d2_mem_data_oe, d2_mem_nwrite_enable, d2_mem_nread_enable;

   logic [3:0] ram     [256];
   logic [3:0] ref_mem [256];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rsp_cnt  = 0;
   int acc_cyc[$];

   always #5 clk = ~clk;

   ram_bus_master u_dut (
      .clk               (clk),
      .nrst              (nrst),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_write         (req_write),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .rsp_valid         (rsp_valid),
      .rsp_rdata         (rsp_rdata),
      .mem_address       (mem_address),
      .mem_data_out      (mem_data_out),
      .mem_data_oe       (mem_data_oe),
      .mem_data_in       (mem_data_in),
      .mem_nwrite_enable (mem_nwrite_enable),
      .mem_nread_enable  (mem_nread_enable)
   );

   ram_bus_master #(
      .SETUP_CYCLES  (3),
      .STROBE_CYCLES (1),
      .HOLD_CYCLES   (2)
   ) u_dut2 (
      .clk               (clk),
      .nrst              (nrst),
      .req_valid         (d2_req_valid),
      .req_ready         (d2_req_ready),
      .req_write         (d2_req_write),
      .req_addr          (d2_req_addr),
      .req_wdata         (d2_req_wdata),
      .rsp_valid         (d2_rsp_valid),
      .rsp_rdata         (d2_rsp_rdata),
      .mem_address       (d2_mem_address),
      .mem_data_out      (d2_mem_data_out),
      .mem_data_oe       (d2_mem_data_oe),
      .mem_data_in       (d2_mem_data_in),
      .mem_nwrite_enable (d2_mem_nwrite_enable),
      .mem_nread_enable  (d2_mem_nread_enable)
   );

   assign mem_data_in    = ram[mem_address];
   assign d2_mem_data_in = d2_mem_address[3:0] ^ 4'h9;

   always @(negedge clk) begin
      if (nrst && !mem_nwrite_enable) ram[mem_address] <= mem_data_out;
   end

   always @(posedge clk) begin
      if (nrst && req_valid && req_ready) acc_cyc.push_back(cyc);
      if (rsp_valid) rsp_cnt = rsp_cnt + 1;
      cyc = cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (obs !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Bus invariants and output stability within each clock period.
   logic [14:0] snap;
   logic        snap_ok = 1'b0;

   always @(posedge clk) begin
      #1;
      snap    = {mem_nwrite_enable, mem_nread_enable, mem_data_oe, mem_address, mem_data_out};
      snap_ok = nrst;
   end

   always @(negedge clk) begin
      if (nrst) begin
         chk("dual_strobe", 32'(!mem_nwrite_enable && !mem_nread_enable), 0);
         chk("oe_during_read", 32'(mem_data_oe && !mem_nread_enable), 0);
         if (snap_ok)
            chk("mem_out_stable", 32'({mem_nwrite_enable, mem_nread_enable, mem_data_oe,
                                       mem_address, mem_data_out}), 32'(snap));
      end
   end

   task automatic wait_ready();
      int g = 0;
      @(negedge clk);
      while (!req_ready && g < 40) begin
         @(negedge clk);
         g++;
      end
      chk("ready_wait", 32'(req_ready), 1);
   endtask

   task automatic run_txn(input logic w, input logic [7:0] a, input logic [3:0] d);
      int g;
      int rc0;
      wait_ready();
      rc0       = rsp_cnt;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0;
      if (w) begin
         ref_mem[a] = d;
         for (int k = 2; k <= 6; k++) @(negedge clk);
         chk("write_no_rsp", 32'(rsp_cnt - rc0), 0);
      end else begin
         g = 0;
         while (!rsp_valid && g < 20) begin
            @(negedge clk);
            g++;
         end
         chk("rsp_wait", 32'(rsp_valid), 1);
         chk("rd_data", 32'(rsp_rdata), 32'(ref_mem[a]));
      end
   endtask

   // Cycle-by-cycle trace with default timing: accept in cycle 0, SETUP 1,
   // STROBE 2-3, HOLD 4, IDLE from 5. For reads d is the expected read data.
   task automatic trace_txn(input logic w, input logic [7:0] a, input logic [3:0] d);
      logic strobe_k;
      wait_ready();
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) req_valid = 1'b0;
         strobe_k = (k == 2) || (k == 3);
         chk($sformatf("tr_nwe_k%0d", k), 32'(mem_nwrite_enable), 32'(!(w && strobe_k)));
         chk($sformatf("tr_nre_k%0d", k), 32'(mem_nread_enable), 32'(!(!w && strobe_k)));
         chk($sformatf("tr_oe_k%0d", k), 32'(mem_data_oe), 32'(w && k >= 1 && k <= 4));
         chk($sformatf("tr_rv_k%0d", k), 32'(rsp_valid), 32'(!w && k == 5));
         chk($sformatf("tr_rdy_k%0d", k), 32'(req_ready), 32'(k >= 5));
         if (k <= 4) chk($sformatf("tr_addr_k%0d", k), 32'(mem_address), 32'(a));
         if (w && k <= 4) chk($sformatf("tr_dout_k%0d", k), 32'(mem_data_out), 32'(d));
         if (!w && k == 5) chk("tr_rdata", 32'(rsp_rdata), 32'(d));
      end
      if (w) ref_mem[a] = d;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      int g;
      int rc0;
      logic       w;
      logic [7:0] a;
      logic [3:0] d;

      nrst = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 4'h0;
      d2_req_valid = 1'b0; d2_req_write = 1'b0; d2_req_addr = 8'h00; d2_req_wdata = 4'h0;

      #12;
      chk("rst_ready", 32'(req_ready), 1);
      chk("rst_nwe", 32'(mem_nwrite_enable), 1);
      chk("rst_nre", 32'(mem_nread_enable), 1);
      chk("rst_oe", 32'(mem_data_oe), 0);
      chk("rst_addr", 32'(mem_address), 0);
      chk("rst_dout", 32'(mem_data_out), 0);
      chk("rst_rv", 32'(rsp_valid), 0);
      chk("rst_rdata", 32'(rsp_rdata), 0);
      @(negedge clk);
      nrst = 1'b1;

      // Fill the RAM through the DUT so every location has a known value.
      for (int i = 0; i < 256; i++) run_txn(1'b1, 8'(i), 4'(i * 7 + 3));

      // Directed write then read of 0x3C.
      trace_txn(1'b1, 8'h3C, 4'hA);
      chk("ram_3c", 32'(ram[8'h3C]), 32'hA);
      trace_txn(1'b0, 8'h3C, 4'hA);

      // Back-to-back write 0x5 @ 0xFF then read, req_valid held high.
      wait_ready();
      n0 = acc_cyc.size();
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'hFF; req_wdata = 4'h5;
      g = 0;
      while (acc_cyc.size() < n0 + 1 && g < 20) begin @(negedge clk); g++; end
      chk("b2b_first_acc", 32'(acc_cyc.size()), 32'(n0 + 1));
      req_write = 1'b0;
      chk("rdata_held", 32'(rsp_rdata), 32'hA);
      g = 0;
      while (acc_cyc.size() < n0 + 2 && g < 20) begin @(negedge clk); g++; end
      req_valid = 1'b0;
      if (acc_cyc.size() >= n0 + 2) begin
         chk("b2b_period", 32'(acc_cyc[n0 + 1] - acc_cyc[n0]), 5);
      end else begin
         chk("b2b_second_acc", 32'(acc_cyc.size()), 32'(n0 + 2));
      end
      ref_mem[8'hFF] = 4'h5;
      g = 0;
      while (!rsp_valid && g < 20) begin @(negedge clk); g++; end
      chk("b2b_rsp", 32'(rsp_valid), 1);
      chk("b2b_rdata", 32'(rsp_rdata), 32'h5);

      // Reset during the STROBE of a write to 0x10 (same data as stored).
      wait_ready();
      rc0 = rsp_cnt;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = ref_mem[8'h10];
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("strobe_reached", 32'(mem_nwrite_enable), 0);
      #2 nrst = 1'b0;
      #1;
      chk("mid_rst_nwe", 32'(mem_nwrite_enable), 1);
      chk("mid_rst_nre", 32'(mem_nread_enable), 1);
      chk("mid_rst_oe", 32'(mem_data_oe), 0);
      chk("mid_rst_addr", 32'(mem_address), 0);
      chk("mid_rst_ready", 32'(req_ready), 1);
      @(negedge clk);
      #2 nrst = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(req_ready), 1);
      for (int k = 0; k < 6; k++) @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_cnt - rc0), 0);

      // Reset during SETUP of a write to 0x10 with new data: RAM unchanged.
      wait_ready();
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = ~ref_mem[8'h10];
      @(negedge clk);
      req_valid = 1'b0;
      chk("setup_reached", 32'(mem_data_oe), 1);
      #2 nrst = 1'b0;
      #1;
      chk("setup_rst_oe", 32'(mem_data_oe), 0);
      chk("setup_rst_nwe", 32'(mem_nwrite_enable), 1);
      @(negedge clk);
      #2 nrst = 1'b1;
      for (int k = 0; k < 6; k++) @(negedge clk);
      chk("ram_10_kept", 32'(ram[8'h10]), 32'(ref_mem[8'h10]));
      run_txn(1'b0, 8'h10, 4'h0);

      // Non-default timing: SETUP 3, STROBE 1, HOLD 2, read of 0x00.
      @(negedge clk);
      chk("d2_ready", 32'(d2_req_ready), 1);
      d2_req_valid = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) d2_req_valid = 1'b0;
         chk($sformatf("d2_nre_k%0d", k), 32'(d2_mem_nread_enable), 32'(k != 4));
         chk($sformatf("d2_nwe_k%0d", k), 32'(d2_mem_nwrite_enable), 1);
         chk($sformatf("d2_oe_k%0d", k), 32'(d2_mem_data_oe), 0);
         chk($sformatf("d2_rv_k%0d", k), 32'(d2_rsp_valid), 32'(k == 7));
         chk($sformatf("d2_rdy_k%0d", k), 32'(d2_req_ready), 32'(k >= 7));
         if (k == 7) chk("d2_rdata", 32'(d2_rsp_rdata), 32'h9);
      end
      chk("d2_dout", 32'(d2_mem_data_out), 0);

      // Random mix against the reference model.
      for (int i = 0; i < 1000; i++) begin
         w = 1'($urandom_range(0, 1));
         a = 8'($urandom_range(0, 255));
         d = 4'($urandom_range(0, 15));
         run_txn(w, a, d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
